// File: rtl/manchester_link_pkg.sv
// Shared types and default parameters for the Manchester link controller.
package manchester_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        RESYNC  = 2'd3
    } link_state_t;

    localparam int unsigned LOCK_BITS_DEFAULT      = 8;
    localparam int unsigned MISS_LIMIT_DEFAULT     = 2;
    localparam int unsigned SILENCE_CYCLES_DEFAULT = 64;
    localparam int unsigned RESYNC_CYCLES_DEFAULT  = 2;

endpackage

// File: rtl/link_silence_timer.sv
// Counts cycles without a line edge; expire is a one-cycle strobe when LIMIT is reached.
module link_silence_timer
    import manchester_link_pkg::*;
#(
    parameter int unsigned LIMIT = SILENCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a held-off clear cannot produce a second strobe.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count  <= '0;
            expire <= 1'b0;
        end else begin
            if (count != CW'(LIMIT)) begin
                count <= count + 1'b1;
            end
            expire <= (count == CW'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/manchester_link_controller.sv
// Lock qualification, bit sampling and resync sequencing for the Manchester recovery loop.
// Define LINK_CTRL_STATS_EN to build the saturating lock-loss counter.
module manchester_link_controller
    import manchester_link_pkg::*;
#(
    parameter int unsigned LOCK_BITS      = LOCK_BITS_DEFAULT,
    parameter int unsigned MISS_LIMIT     = MISS_LIMIT_DEFAULT,
    parameter int unsigned SILENCE_CYCLES = SILENCE_CYCLES_DEFAULT,
    parameter int unsigned RESYNC_CYCLES  = RESYNC_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       digital_in,
    input  logic       pos_edge,
    input  logic       neg_edge,
    input  logic       manchester_clock,
    output logic       recovery_reset,
    output logic       locked,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       lock_lost,
    output logic [1:0] link_state,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned QW = $clog2(LOCK_BITS + 1);
    localparam int unsigned MW = $clog2(MISS_LIMIT + 1);
    localparam int unsigned RW = $clog2(RESYNC_CYCLES + 1);

    link_state_t   state, state_next;
    logic [QW-1:0] qual_cnt, qual_next, qual_inc;
    logic [MW-1:0] miss_cnt, miss_next, miss_inc;
    logic [RW-1:0] rs_cnt, rs_next;
    logic          mc_q, edge_seen, edge_seen_next;
    logic          bit_valid_next, bit_data_next, lock_lost_next;
    logic          rise, edge_now, period_edge;
    logic          silence_clear, silence_expire;

    assign rise          = manchester_clock & ~mc_q;
    assign edge_now      = pos_edge | neg_edge;
    assign period_edge   = edge_seen | edge_now;
    assign silence_clear = edge_now || (state == IDLE) || (state == RESYNC);
    assign qual_inc      = (qual_cnt == QW'(LOCK_BITS)) ? qual_cnt : qual_cnt + 1'b1;
    assign miss_inc      = (miss_cnt == MW'(MISS_LIMIT)) ? miss_cnt : miss_cnt + 1'b1;
    assign link_state    = state;

    link_silence_timer #(
        .LIMIT (SILENCE_CYCLES)
    ) u_silence (
        .clock  (clock),
        .reset  (reset),
        .clear  (silence_clear),
        .expire (silence_expire)
    );

    // Next-state and next-output decode; enable and silence override per-state logic.
    always_comb begin
        state_next     = state;
        qual_next      = qual_cnt;
        miss_next      = miss_cnt;
        rs_next        = rs_cnt;
        edge_seen_next = rise ? 1'b0 : period_edge;
        bit_valid_next = 1'b0;
        bit_data_next  = bit_data;
        lock_lost_next = 1'b0;

        if (!enable) begin
            state_next     = IDLE;
            qual_next      = '0;
            miss_next      = '0;
            rs_next        = '0;
            edge_seen_next = 1'b0;
            bit_data_next  = 1'b0;
        end else if (silence_expire && (state == ACQUIRE || state == LOCKED)) begin
            state_next     = RESYNC;
            lock_lost_next = (state == LOCKED);
            qual_next      = '0;
            miss_next      = '0;
            rs_next        = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next     = ACQUIRE;
                    qual_next      = '0;
                    miss_next      = '0;
                    rs_next        = '0;
                    edge_seen_next = 1'b0;
                end
                ACQUIRE: begin
                    if (rise) begin
                        if (period_edge) begin
                            qual_next = qual_inc;
                            if (qual_inc == QW'(LOCK_BITS)) begin
                                state_next = LOCKED;
                                miss_next  = '0;
                            end
                        end else begin
                            qual_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        bit_valid_next = 1'b1;
                        bit_data_next  = digital_in;
                        miss_next      = period_edge ? '0 : miss_inc;
                        if (!period_edge && miss_inc == MW'(MISS_LIMIT)) begin
                            state_next     = RESYNC;
                            lock_lost_next = 1'b1;
                            qual_next      = '0;
                            miss_next      = '0;
                            rs_next        = '0;
                        end
                    end
                end
                RESYNC: begin
                    edge_seen_next = 1'b0;
                    if (rs_cnt == RW'(RESYNC_CYCLES - 1)) begin
                        state_next = ACQUIRE;
                        qual_next  = '0;
                        miss_next  = '0;
                        rs_next    = '0;
                    end else begin
                        rs_next = rs_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // recovery_reset follows the current state, so it lags state entry by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            qual_cnt       <= '0;
            miss_cnt       <= '0;
            rs_cnt         <= '0;
            mc_q           <= 1'b0;
            edge_seen      <= 1'b0;
            recovery_reset <= 1'b1;
            locked         <= 1'b0;
            bit_valid      <= 1'b0;
            bit_data       <= 1'b0;
            lock_lost      <= 1'b0;
        end else begin
            state          <= state_next;
            qual_cnt       <= qual_next;
            miss_cnt       <= miss_next;
            rs_cnt         <= rs_next;
            mc_q           <= manchester_clock;
            edge_seen      <= edge_seen_next;
            recovery_reset <= (state == IDLE) || (state == RESYNC);
            locked         <= (state_next == LOCKED);
            bit_valid      <= bit_valid_next;
            bit_data       <= bit_data_next;
            lock_lost      <= lock_lost_next;
        end
    end

`ifdef LINK_CTRL_STATS_EN
    logic [7:0] loss_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            loss_count <= 8'd0;
        end else if (lock_lost_next && loss_count != 8'hFF) begin
            loss_count <= loss_count + 8'd1;
        end
    end

    assign lock_loss_count = loss_count;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_manchester_link_controller.sv
// Directed bench for manchester_link_controller: acquisition, bit sampling, miss/silence resync, enable drop.
module tb_manchester_link_controller;

    logic       clock = 1'b0;
    logic       reset, enable, digital_in, pos_edge, neg_edge, manchester_clock;
    logic       recovery_reset, locked, bit_valid, bit_data, lock_lost;
    logic [1:0] link_state;
    logic [7:0] lock_loss_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LINK_CTRL_STATS_EN
    localparam int LOSS_EXP = 1;
`else
    localparam int LOSS_EXP = 0;
`endif

    // Per-period observations filled by run_period.
    int         bv0, bd0, lk0, lost0, st0, st1, st2, bv_cnt, lost_cnt;
    logic [6:0] rr_bits;

    always #5 clock = ~clock;

    manchester_link_controller dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .digital_in       (digital_in),
        .pos_edge         (pos_edge),
        .neg_edge         (neg_edge),
        .manchester_clock (manchester_clock),
        .recovery_reset   (recovery_reset),
        .locked           (locked),
        .bit_valid        (bit_valid),
        .bit_data         (bit_data),
        .lock_lost        (lock_lost),
        .link_state       (link_state),
        .lock_loss_count  (lock_loss_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then land 1 time unit after the sampling edge.
    task automatic cyc(input logic mc_v, input logic pe_v, input logic din_v);
        manchester_clock = mc_v;
        pos_edge         = pe_v;
        neg_edge         = 1'b0;
        digital_in       = din_v;
        @(posedge clock);
        #1;
    endtask

    // One 7-cycle recovered period: clock high for j=0..2, rise at j=0, optional edge at j=epos.
    task automatic run_period(input int epos, input logic din_v);
        bv_cnt   = 0;
        lost_cnt = 0;
        rr_bits  = '0;
        for (int j = 0; j < 7; j++) begin
            cyc(j < 3, j == epos, din_v);
            if (j == 0) begin
                bv0   = int'(bit_valid);
                bd0   = int'(bit_data);
                lk0   = int'(locked);
                lost0 = int'(lock_lost);
                st0   = int'(link_state);
            end
            if (j == 1) st1 = int'(link_state);
            if (j == 2) st2 = int'(link_state);
            rr_bits[j] = recovery_reset;
            bv_cnt   += int'(bit_valid);
            lost_cnt += int'(lock_lost);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acq;
        int quiet_lost;

        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("reset_state", int'(link_state), 0);
        check_eq("reset_rr", int'(recovery_reset), 1);
        check_eq("reset_locked", int'(locked), 0);
        check_eq("reset_bit_valid", int'(bit_valid), 0);
        check_eq("reset_bit_data", int'(bit_data), 0);
        check_eq("reset_lock_lost", int'(lock_lost), 0);
        check_eq("reset_loss_count", int'(lock_loss_count), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("idle_stays", int'(link_state), 0);

        // Acquisition: edge in every rise cycle, lock on the 8th qualifying rise.
        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("acq_enter_state", int'(link_state), 1);
        check_eq("acq_rr_cycle1", int'(recovery_reset), 1);
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("acq_rr_cycle2", int'(recovery_reset), 0);
        for (int p = 1; p <= 7; p++) run_period(0, 1'b0);
        check_eq("acq_rise7_unlocked", lk0, 0);
        check_eq("acq_rise7_state", st0, 1);
        check_eq("acq_rr_low", int'(rr_bits), 0);
        run_period(0, 1'b0);
        check_eq("acq_rise8_locked", lk0, 1);
        check_eq("acq_rise8_state", st0, 2);
        check_eq("acq_rise8_no_bit", bv0, 0);

        // Locked bit sampling with mid-period edges.
        run_period(3, 1'b1);
        check_eq("bit9_valid", bv0, 1);
        check_eq("bit9_data", bd0, 1);
        check_eq("bit9_single_pulse", bv_cnt, 1);
        run_period(3, 1'b0);
        check_eq("bit10_valid", bv0, 1);
        check_eq("bit10_data", bd0, 0);
        run_period(3, 1'b1);
        check_eq("bit11_data", bd0, 1);

        // Edges stop: rise 12 still sees period 11's edge, rises 13 and 14 miss.
        run_period(7, 1'b0);
        check_eq("miss12_data", bd0, 0);
        check_eq("miss12_locked", lk0, 1);
        run_period(7, 1'b1);
        check_eq("miss13_data", bd0, 1);
        check_eq("miss13_no_loss", lost0, 0);
        run_period(7, 1'b0);
        check_eq("miss14_bit_valid", bv0, 1);
        check_eq("miss14_bit_data", bd0, 0);
        check_eq("miss14_lock_lost", lost0, 1);
        check_eq("miss14_loss_pulses", lost_cnt, 1);
        check_eq("miss14_locked", lk0, 0);
        check_eq("miss14_state", st0, 3);
        check_eq("miss14_state_n2", st1, 3);
        check_eq("miss14_rr_pattern", int'(rr_bits), 6);
        check_eq("miss14_reacquire", st2, 1);
        check_eq("miss14_loss_count", int'(lock_loss_count), LOSS_EXP);

        // Re-acquire after resync.
        for (int p = 1; p <= 7; p++) run_period(0, 1'b0);
        check_eq("reacq_rise7_unlocked", lk0, 0);
        run_period(0, 1'b0);
        check_eq("reacq_locked", lk0, 1);

        // Single-cycle enable drop from LOCKED.
        enable = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("drop_state", int'(link_state), 0);
        check_eq("drop_locked", int'(locked), 0);
        check_eq("drop_lock_lost", int'(lock_lost), 0);
        check_eq("drop_bit_valid", int'(bit_valid), 0);
        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("reenable_state", int'(link_state), 1);
        check_eq("reenable_rr", int'(recovery_reset), 1);
        check_eq("reenable_loss_count", int'(lock_loss_count), LOSS_EXP);

        // Silence in ACQUIRE: 64 quiet cycles, expiry seen one cycle later.
        n_acq      = 0;
        quiet_lost = 0;
        for (int i = 0; i < 200; i++) begin
            quiet_lost += int'(lock_lost);
            if (link_state != 2'd1) break;
            n_acq++;
            cyc(1'b0, 1'b0, 1'b0);
        end
        check_eq("silence_acq_cycles", n_acq, 65);
        check_eq("silence_state", int'(link_state), 3);
        check_eq("silence_no_lock_lost", quiet_lost, 0);
        check_eq("silence_loss_count", int'(lock_loss_count), LOSS_EXP);
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("silence_resync_hold", int'(link_state), 3);
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("silence_reacquire", int'(link_state), 1);
        check_eq("silence_rr_high", int'(recovery_reset), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
